mini_bit_link_host: RTL and testbench
=====================================

Name: mini_bit_link_host

Overview:
- Host-side peer of the mini_bit serial pins; the other end of the CPU's rx/tx link.
- Serialises bytes from a host valid/ready interface onto the CPU's rx line.
- Deserialises frames the CPU sequencer drives on its tx line and presents them as byte strobes.
- Sits on the testbench/board side of mini_bit; full duplex, both directions independent.

Parameters:
- BIT_CLKS, 16, clk cycles per serial bit; even, ≥4.
- SYNC_STAGES, 2, flops in cpu_tx input synchroniser; ≥2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cpu_tx  input  1  serial line driven by mini_bit tx; idle high.
- cpu_rx  output  1  serial line to mini_bit rx; idle high.
- tx_data  input  8  byte to send to the CPU.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  transmitter can accept a byte.
- rx_data  output  8  last good byte received from the CPU.
- rx_valid  output  1  one-cycle strobe: rx_data updated.
- rx_err  output  1  one-cycle strobe: framing error.
- busy  output  1  high while either direction is mid-frame.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. Every flop clears on rst_n low, with no clk needed.
- Reset values: cpu_rx=1, tx_ready=1, rx_data=0, rx_valid=0, rx_err=0, busy=0, synchroniser flops=1.
- Frame format: start bit (0), 8 data bits LSB first, stop bit (1). Each bit lasts exactly BIT_CLKS cycles.
- TX FSM states: IDLE -> START -> DATA -> STOP -> IDLE.
- TX handshake: transfer occurs on a clk edge with tx_valid&tx_ready. tx_data is latched at that edge; later changes are ignored.
- tx_ready is 1 only in IDLE.
- cpu_rx falls on the edge after the handshake and is held low BIT_CLKS cycles. Data bits follow, then the stop bit high for BIT_CLKS cycles.
- tx_ready re-asserts the cycle after the stop bit completes. Handshake to next possible handshake is 10*BIT_CLKS+1 cycles.
- TX back-to-back: if tx_valid is held, frames are sent with no idle gap beyond that one cycle.
- RX synchroniser: cpu_tx passes through SYNC_STAGES flops; only the synchronised value is used.
- RX FSM states: IDLE -> START -> DATA -> STOP -> (IDLE | BREAK).
- IDLE: a synchronised 1->0 transition enters START and zeroes the bit counter.
- START: samples at BIT_CLKS/2. If the line is high, it is a false start: return to IDLE, no strobe.
- DATA: samples every BIT_CLKS cycles after the start sample (mid-bit), shifting in LSB first.
- STOP sample = 1: rx_data loads the shifted byte and rx_valid pulses for one cycle (the edge after the sample). Then IDLE.
- STOP sample = 0: rx_err pulses for one cycle and rx_data is unchanged. Enter BREAK, which waits for the synchronised line to return to 1, then IDLE.
- rx_valid latency: exactly SYNC_STAGES + BIT_CLKS/2 + 9*BIT_CLKS + 1 cycles after the first clk edge sampling cpu_tx low. Bench tolerance is ±1.
- rx_valid and rx_err are never high together. No overrun detection: the host must consume rx_data before the next strobe.
- Simultaneous TX handshake and RX strobe are independent; both take effect.
- Reset mid-frame: the frame is abandoned, cpu_rx goes high immediately, and no strobe is produced.
- busy = (TX state != IDLE) | (RX state != IDLE).

Optional Feature:
- Macro: MINI_BIT_LINK_PARITY_EN.
- Defined: an even-parity bit is inserted between data bit 7 and the stop bit in both directions, so a frame is 11 bits.
  - TX drives the XOR of the 8 data bits.
  - RX checks the parity bit. On mismatch with a good stop bit, rx_err pulses instead of rx_valid and rx_data is unchanged.
  - rx_valid latency grows by BIT_CLKS.
- Undefined: 10-bit frames with no parity logic.

Test Plan:
- Reset with BIT_CLKS=16, then tx_data=0xA5 with tx_valid for one cycle -> cpu_rx reads 0,1,0,1,0,0,1,0,1,1, each held 16 cycles; tx_ready low for 161 cycles.
- Drive cpu_tx with a frame for 0x3C at 16 clks/bit -> rx_data=0x3C and a single rx_valid pulse at 2+8+144+1=155 cycles ±1 after the start edge.
- Drive cpu_tx with a frame for 0x81 whose stop bit is 0, held low 40 cycles -> one rx_err pulse, rx_data keeps its previous value. No reception until the line is high; the next frame 0x55 is received correctly.
- Drive a 4-cycle low glitch on cpu_tx -> no strobe, RX back in IDLE, busy low.
- Full duplex: send 0xFF while receiving 0x00 simultaneously, then assert rst_n low mid-frame -> both bytes are correct before reset. After reset, cpu_rx=1, tx_ready=1, no strobes.
- With MINI_BIT_LINK_PARITY_EN: transmit 0x07 -> parity bit 1. Receive 0x07 with parity 0 -> rx_err pulse, no rx_valid.

Source files
------------

// File: rtl/mini_bit_link_host.sv
// Host-side peer of the mini_bit serial pins: byte TX onto cpu_rx, frame RX from cpu_tx.
// Define MINI_BIT_LINK_PARITY_EN to add an even-parity bit before the stop bit.
module mini_bit_link_host #(
   parameter int BIT_CLKS    = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cpu_tx,
   output logic       cpu_rx,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_err,
   output logic       busy
);

   localparam int CW = $clog2(BIT_CLKS + 1);
   localparam logic [CW-1:0] C_LAST = CW'(BIT_CLKS - 1);
   localparam logic [CW-1:0] C_END  = CW'(BIT_CLKS);
   localparam logic [CW-1:0] C_HALF = CW'(BIT_CLKS / 2);
   localparam logic [CW-1:0] C_ONE  = CW'(1);

   typedef enum logic [2:0] {
      TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_BREAK
   } rx_state_t;

   tx_state_t tx_state_q, tx_state_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0] tx_bit_q, tx_bit_d;
   logic [7:0] tx_sh_q, tx_sh_d;
   logic cpu_rx_q, cpu_rx_d;

   rx_state_t rx_state_q, rx_state_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0] rx_bit_q, rx_bit_d;
   logic [7:0] rx_sh_q, rx_sh_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic rx_valid_q, rx_valid_d;
   logic rx_err_q, rx_err_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic rx_prev_q, rx_prev_d;
   logic rx_s;

`ifdef MINI_BIT_LINK_PARITY_EN
   logic tx_par_q, tx_par_d;
   logic rx_perr_q, rx_perr_d;
`endif

   assign rx_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q + C_ONE;
      tx_bit_d   = tx_bit_q;
      tx_sh_d    = tx_sh_q;
      cpu_rx_d   = cpu_rx_q;
`ifdef MINI_BIT_LINK_PARITY_EN
      tx_par_d   = tx_par_q;
`endif
      case (tx_state_q)
         TX_IDLE: begin
            tx_cnt_d = '0;
            cpu_rx_d = 1'b1;
            if (tx_valid) begin
               tx_state_d = TX_START;
               tx_sh_d    = tx_data;
               cpu_rx_d   = 1'b0;
`ifdef MINI_BIT_LINK_PARITY_EN
               tx_par_d   = ^tx_data;
`endif
            end
         end
         TX_START: begin
            if (tx_cnt_q == C_LAST) begin
               tx_state_d = TX_DATA;
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
               cpu_rx_d   = tx_sh_q[0];
            end
         end
         TX_DATA: begin
            if (tx_cnt_q == C_LAST) begin
               tx_cnt_d = '0;
               if (tx_bit_q == 3'd7) begin
`ifdef MINI_BIT_LINK_PARITY_EN
                  tx_state_d = TX_PAR;
                  cpu_rx_d   = tx_par_q;
`else
                  tx_state_d = TX_STOP;
                  cpu_rx_d   = 1'b1;
`endif
               end else begin
                  tx_bit_d = tx_bit_q + 3'd1;
                  tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                  cpu_rx_d = tx_sh_q[1];
               end
            end
         end
`ifdef MINI_BIT_LINK_PARITY_EN
         TX_PAR: begin
            if (tx_cnt_q == C_LAST) begin
               tx_state_d = TX_STOP;
               tx_cnt_d   = '0;
               cpu_rx_d   = 1'b1;
            end
         end
`endif
         // one extra stop cycle gives the idle slot before tx_ready returns
         TX_STOP: begin
            if (tx_cnt_q == C_END) begin
               tx_state_d = TX_IDLE;
               tx_cnt_d   = '0;
            end
         end
         default: begin
            tx_state_d = TX_IDLE;
            cpu_rx_d   = 1'b1;
         end
      endcase
   end

   always_comb begin
      sync_d     = {sync_q[SYNC_STAGES-2:0], cpu_tx};
      rx_prev_d  = rx_s;
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q + C_ONE;
      rx_bit_d   = rx_bit_q;
      rx_sh_d    = rx_sh_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      rx_err_d   = 1'b0;
`ifdef MINI_BIT_LINK_PARITY_EN
      rx_perr_d  = rx_perr_q;
`endif
      case (rx_state_q)
         RX_IDLE: begin
            rx_cnt_d = '0;
            if (rx_prev_q && !rx_s) rx_state_d = RX_START;
         end
         RX_START: begin
            if (rx_cnt_q == C_HALF) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = rx_s ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == C_LAST) begin
               rx_cnt_d = '0;
               rx_sh_d  = {rx_s, rx_sh_q[7:1]};
               rx_bit_d = rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) begin
`ifdef MINI_BIT_LINK_PARITY_EN
                  rx_state_d = RX_PAR;
`else
                  rx_state_d = RX_STOP;
`endif
               end
            end
         end
`ifdef MINI_BIT_LINK_PARITY_EN
         RX_PAR: begin
            if (rx_cnt_q == C_LAST) begin
               rx_cnt_d   = '0;
               rx_perr_d  = rx_s ^ (^rx_sh_q);
               rx_state_d = RX_STOP;
            end
         end
`endif
         RX_STOP: begin
            if (rx_cnt_q == C_LAST) begin
               rx_cnt_d   = '0;
               rx_state_d = RX_IDLE;
               if (!rx_s) begin
                  rx_err_d   = 1'b1;
                  rx_state_d = RX_BREAK;
               end
`ifdef MINI_BIT_LINK_PARITY_EN
               else if (rx_perr_q) begin
                  rx_err_d = 1'b1;
               end
`endif
               else begin
                  rx_valid_d = 1'b1;
                  rx_data_d  = rx_sh_q;
               end
            end
         end
         RX_BREAK: begin
            rx_cnt_d = '0;
            if (rx_s) rx_state_d = RX_IDLE;
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_sh_q    <= '0;
         cpu_rx_q   <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_sh_q    <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_err_q   <= 1'b0;
         sync_q     <= '1;
         rx_prev_q  <= 1'b1;
`ifdef MINI_BIT_LINK_PARITY_EN
         tx_par_q   <= 1'b0;
         rx_perr_q  <= 1'b0;
`endif
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_sh_q    <= tx_sh_d;
         cpu_rx_q   <= cpu_rx_d;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_sh_q    <= rx_sh_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         rx_err_q   <= rx_err_d;
         sync_q     <= sync_d;
         rx_prev_q  <= rx_prev_d;
`ifdef MINI_BIT_LINK_PARITY_EN
         tx_par_q   <= tx_par_d;
         rx_perr_q  <= rx_perr_d;
`endif
      end
   end

   assign cpu_rx   = cpu_rx_q;
   assign tx_ready = (tx_state_q == TX_IDLE);
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign rx_err   = rx_err_q;
   assign busy     = (tx_state_q != TX_IDLE) | (rx_state_q != RX_IDLE);

endmodule

// File: tb/tb_mini_bit_link_host.sv
// Directed bench for mini_bit_link_host at BIT_CLKS=16, SYNC_STAGES=2.
// Honours MINI_BIT_LINK_PARITY_EN for frame length and parity cases.
`timescale 1ns/1ps
module tb_mini_bit_link_host;

`ifdef MINI_BIT_LINK_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int BC  = 16;
   localparam int LAT = 2 + BC/2 + (NB-1)*BC + 1;
   localparam int RDY = NB*BC + 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic cpu_tx = 1'b1;
   logic cpu_rx;
   logic [7:0] tx_data = 8'h00;
   logic tx_valid = 1'b0;
   logic tx_ready;
   logic [7:0] rx_data;
   logic rx_valid;
   logic rx_err;
   logic busy;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int vcnt = 0;
   int ecnt = 0;
   int both = 0;
   int vcyc = 0;
   int start_cyc = 0;

   mini_bit_link_host #(.BIT_CLKS(BC), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_tx(cpu_tx), .cpu_rx(cpu_rx),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
      .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (rst_n) begin
         if (rx_valid) begin
            vcnt++;
            vcyc = cyc;
         end
         if (rx_err) ecnt++;
         if (rx_valid && rx_err) both++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic fbit(input logic [7:0] d, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return d[k-1];
`ifdef MINI_BIT_LINK_PARITY_EN
      if (k == 9) return ^d;
`endif
      return 1'b1;
   endfunction

   task automatic send_tx(input logic [7:0] d, output logic [15:0] bits);
      int rdy_at;
      bits = '0;
      rdy_at = -1;
      @(negedge clk);
      tx_data = d;
      tx_valid = 1'b1;
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      tx_data = ~d;
      chk("tx_rdy_lo", {31'd0, tx_ready}, 32'd0);
      for (int c = 1; c <= NB*BC + 10; c++) begin
         @(posedge clk);
         #1;
         if (c % BC == BC/2 && c / BC < NB) begin
            bits[c/BC] = cpu_rx;
            chk("tx_bit", {c/BC, cpu_rx}, {c/BC, fbit(d, c/BC)});
         end
         if (tx_ready && rdy_at < 0) rdy_at = c;
      end
      chk("tx_rdy_at", rdy_at, RDY);
   endtask

   task automatic drv_rx(input logic [7:0] d, input logic par,
                         input logic stop, input int stop_len);
      @(negedge clk);
      start_cyc = cyc;
      cpu_tx = 1'b0;
      repeat (BC) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         cpu_tx = d[i];
         repeat (BC) @(negedge clk);
      end
`ifdef MINI_BIT_LINK_PARITY_EN
      cpu_tx = par;
      repeat (BC) @(negedge clk);
`else
      if (par) cpu_tx = 1'b0;
`endif
      cpu_tx = stop;
      repeat (stop_len) @(negedge clk);
      cpu_tx = 1'b1;
   endtask

   initial begin
      logic [15:0] bits;
      int lat;
      repeat (3) @(negedge clk);
      chk("rst_cpu_rx", {31'd0, cpu_rx}, 32'd1);
      chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
      chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
      chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      chk("rst_rx_err", {31'd0, rx_err}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      send_tx(8'hA5, bits);
      chk("tx_a5_byte", {24'd0, bits[8:1]}, 32'hA5);

      vcnt = 0; ecnt = 0;
      drv_rx(8'h3C, 1'b0, 1'b1, BC);
      repeat (20) @(negedge clk);
      chk("rx_3c_data", {24'd0, rx_data}, 32'h3C);
      chk("rx_3c_vcnt", vcnt, 1);
      chk("rx_3c_ecnt", ecnt, 0);
      lat = vcyc - (start_cyc + 1);
      if (lat < LAT - 1 || lat > LAT + 1)
         chk("rx_3c_lat", lat, LAT);
      else
         chk("rx_3c_lat_ok", {31'd0, vcnt == 1}, 32'd1);

      vcnt = 0; ecnt = 0;
      drv_rx(8'h81, 1'b0, 1'b0, 40);
      repeat (20) @(negedge clk);
      chk("rx_81_ecnt", ecnt, 1);
      chk("rx_81_vcnt", vcnt, 0);
      chk("rx_81_data", {24'd0, rx_data}, 32'h3C);
      chk("rx_81_busy", {31'd0, busy}, 32'd0);
      vcnt = 0; ecnt = 0;
      drv_rx(8'h55, 1'b0, 1'b1, BC);
      repeat (20) @(negedge clk);
      chk("rx_55_data", {24'd0, rx_data}, 32'h55);
      chk("rx_55_vcnt", vcnt, 1);

      vcnt = 0; ecnt = 0;
      @(negedge clk);
      cpu_tx = 1'b0;
      repeat (4) @(negedge clk);
      cpu_tx = 1'b1;
      repeat (40) @(negedge clk);
      chk("glitch_vcnt", vcnt, 0);
      chk("glitch_ecnt", ecnt, 0);
      chk("glitch_busy", {31'd0, busy}, 32'd0);

      vcnt = 0; ecnt = 0;
      fork
         send_tx(8'hFF, bits);
         drv_rx(8'h00, 1'b0, 1'b1, BC);
      join
      repeat (20) @(negedge clk);
      chk("dup_tx_byte", {24'd0, bits[8:1]}, 32'hFF);
      chk("dup_rx_data", {24'd0, rx_data}, 32'h00);
      chk("dup_vcnt", vcnt, 1);

      vcnt = 0; ecnt = 0;
      @(negedge clk);
      tx_data = 8'h00;
      tx_valid = 1'b1;
      cpu_tx = 1'b0;
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      repeat (40) @(negedge clk);
      chk("mid_cpu_rx", {31'd0, cpu_rx}, 32'd0);
      chk("mid_busy", {31'd0, busy}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_cpu_rx", {31'd0, cpu_rx}, 32'd1);
      chk("arst_tx_ready", {31'd0, tx_ready}, 32'd1);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_rx_data", {24'd0, rx_data}, 32'd0);
      cpu_tx = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (200) @(negedge clk);
      chk("post_vcnt", vcnt, 0);
      chk("post_ecnt", ecnt, 0);
      chk("post_cpu_rx", {31'd0, cpu_rx}, 32'd1);
      chk("post_tx_ready", {31'd0, tx_ready}, 32'd1);

`ifdef MINI_BIT_LINK_PARITY_EN
      send_tx(8'h07, bits);
      chk("par_tx_bit", {31'd0, bits[9]}, 32'd1);
      vcnt = 0; ecnt = 0;
      drv_rx(8'h07, 1'b0, 1'b1, BC);
      repeat (20) @(negedge clk);
      chk("par_ecnt", ecnt, 1);
      chk("par_vcnt", vcnt, 0);
      chk("par_data", {24'd0, rx_data}, 32'h00);
`endif

      chk("no_both", both, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
